// File: rtl/luma_bin_pkg.sv
// Shared constants for the 2x2 luma binner: register word indices and adder widths.
package luma_bin_pkg;

  localparam logic [5:0] REG_CTRL = 6'd0;
  localparam logic [5:0] REG_STAT = 6'd1;
  localparam logic [5:0] REG_FMT  = 6'd2;
  localparam logic [5:0] REG_FCNT = 6'd3;

  localparam int HSUM_W = 9;
  localparam int VSUM_W = 10;

endpackage

// File: rtl/luma_bin2x2_if.sv
// Bus bundle for luma_bin2x2: internal register bus plus input and output AXI streams.
interface luma_bin2x2_if;

  // Streams: a beat transfers on a rising clk edge where tvalid and tready are both 1;
  // a producer holding tvalid=1 keeps tdata/tuser/tlast stable until that edge.
  logic        ibus_cs;
  logic        ibus_wr;
  logic [7:0]  ibus_addr;
  logic [31:0] ibus_wrdata;
  logic [31:0] ibus_rddata;

  logic        tvalid_in;
  logic        tready_in;
  logic        tuser_in;
  logic        tlast_in;
  logic [15:0] tdata_in;

  logic        tvalid_out;
  logic        tready_out;
  logic        tuser_out;
  logic        tlast_out;
  logic [7:0]  tdata_out;

  modport slave (
    input  ibus_cs, ibus_wr, ibus_addr, ibus_wrdata,
    output ibus_rddata,
    input  tvalid_in, tuser_in, tlast_in, tdata_in,
    output tready_in,
    output tvalid_out, tuser_out, tlast_out, tdata_out,
    input  tready_out
  );

  modport master (
    output ibus_cs, ibus_wr, ibus_addr, ibus_wrdata,
    input  ibus_rddata,
    output tvalid_in, tuser_in, tlast_in, tdata_in,
    input  tready_in,
    input  tvalid_out, tuser_out, tlast_out, tdata_out,
    output tready_out
  );

endinterface

// File: rtl/luma_bin2x2_lbuf_sdp.sv
// Simple dual-port line buffer: synchronous write, registered read that holds its
// value while the read enable is low.
module lbuf_sdp #(
  parameter int DEPTH = 1024,
  parameter int W     = 9,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/luma_bin2x2.sv
// 2x2 luma binner: YUV422 stream in, half-width/half-height 8-bit luma out.
// Define LUMA_BIN_ROUND_EN to round the 2x2 average half up instead of truncating.
module luma_bin2x2
  import luma_bin_pkg::*;
#(
  parameter int MAX_WIDTH = 2048,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  luma_bin2x2_if.slave  bus
);

  localparam int HALF = MAX_WIDTH / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic              ctrl_q, ctrl_d;
  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     row_q, row_d;
  logic [CW-1:0]     lw_q, lw_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        yh_q, yh_d;
  logic [CW-1:0]     line_cols_q, line_cols_d;
  logic [CW-1:0]     out_cols_q, out_cols_d;
  logic [CW-1:0]     out_rows_q, out_rows_d;
  logic [CW-1:0]     fmt_rows_q, fmt_rows_d;
  logic [CW-1:0]     fmt_cols_q, fmt_cols_d;
  logic [CW-1:0]     fcnt_q, fcnt_d;
  logic              vld_q, vld_d;
  logic              usr_q, usr_d;
  logic              lst_q, lst_d;
  logic [7:0]        dat_q, dat_d;

  logic              en;
  logic              ready_in;
  logic              acc;
  logic              beat;
  logic [CW-1:0]     c_eff;
  logic [CW-1:0]     r_eff;
  logic [CW-1:0]     pair;
  logic              in_rng;
  logic              odd_c;
  logic              odd_r;
  logic [7:0]        y_in;
  logic [HSUM_W-1:0] hsum;
  logic [HSUM_W-1:0] rd_data;
  logic [VSUM_W-1:0] vsum;
  logic [VSUM_W-1:0] vsum_adj;
  logic              rd_en;
  logic              wr_en;
  logic              emit;
  logic              last_pair;
  logic              unused_ok;

  assign en       = ctrl_q;
  assign ready_in = ~en | ~vld_q | bus.tready_out;
  assign acc      = bus.tvalid_in & ready_in;
  assign beat     = acc & en;

  // A tuser beat is pixel (0,0) regardless of where the counters were.
  assign c_eff  = bus.tuser_in ? '0 : col_q;
  assign r_eff  = bus.tuser_in ? '0 : row_q;
  assign pair   = c_eff >> 1;
  assign in_rng = pair < CW'(HALF);
  assign odd_c  = c_eff[0];
  assign odd_r  = r_eff[0];
  assign y_in   = bus.tdata_in[15:8];

  assign hsum  = HSUM_W'(yh_q) + HSUM_W'(y_in);
  assign vsum  = VSUM_W'(rd_data) + VSUM_W'(hsum);
  assign rd_en = beat & ~odd_c & odd_r & in_rng;
  assign wr_en = beat & odd_c & ~odd_r & in_rng;
  assign emit  = beat & odd_c & odd_r & in_rng;

  // The odd row takes its odd-width end marker from the width of the even row above it.
  assign last_pair = lw_q[0] & (pair == ((lw_q >> 1) - CW'(1)));

`ifdef LUMA_BIN_ROUND_EN
  assign vsum_adj = vsum + VSUM_W'(2);
`else
  assign vsum_adj = vsum;
`endif

  lbuf_sdp #(
    .DEPTH (HALF),
    .W     (HSUM_W),
    .AW    (AW)
  ) u_lbuf (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (pair[AW-1:0]),
    .wdata_i (hsum),
    .re_i    (rd_en),
    .raddr_i (pair[AW-1:0]),
    .rdata_o (rd_data)
  );

  always_comb begin
    ctrl_d      = ctrl_q;
    col_d       = col_q;
    row_d       = row_q;
    lw_d        = lw_q;
    pend_d      = pend_q;
    ovf_d       = ovf_q;
    yh_d        = yh_q;
    line_cols_d = line_cols_q;
    out_cols_d  = out_cols_q;
    out_rows_d  = out_rows_q;
    fmt_rows_d  = fmt_rows_q;
    fmt_cols_d  = fmt_cols_q;
    fcnt_d      = fcnt_q;
    vld_d       = vld_q;
    usr_d       = usr_q;
    lst_d       = lst_q;
    dat_d       = dat_q;

    if (bus.ibus_cs && bus.ibus_wr && bus.ibus_addr[7:2] == REG_CTRL)
      ctrl_d = bus.ibus_wrdata[0];

    if (!en) begin
      col_d       = '0;
      row_d       = '0;
      lw_d        = '0;
      pend_d      = 1'b0;
      ovf_d       = 1'b0;
      line_cols_d = '0;
      out_cols_d  = '0;
      out_rows_d  = '0;
      vld_d       = 1'b0;
      usr_d       = 1'b0;
      lst_d       = 1'b0;
    end else begin
      if (vld_q && bus.tready_out) begin
        vld_d = 1'b0;
        if (usr_q) pend_d = 1'b0;
      end

      if (acc) begin
        if (bus.tuser_in) begin
          pend_d      = 1'b1;
          line_cols_d = '0;
          out_rows_d  = '0;
          out_cols_d  = '0;
          if (out_rows_q != '0) begin
            fmt_rows_d = out_rows_q;
            fmt_cols_d = out_cols_q;
            fcnt_d     = fcnt_q + CW'(1);
          end
        end

        if (!odd_c) yh_d = y_in;
        if (!in_rng) ovf_d = 1'b1;

        if (emit) begin
          vld_d       = 1'b1;
          usr_d       = pend_q;
          lst_d       = bus.tlast_in | last_pair;
          dat_d       = vsum_adj[VSUM_W-1:2];
          line_cols_d = line_cols_q + CW'(1);
        end

        if (bus.tlast_in) begin
          col_d       = '0;
          row_d       = r_eff + CW'(1);
          line_cols_d = '0;
          if (!odd_r) begin
            lw_d = c_eff + CW'(1);
          end else if ((line_cols_q + CW'(emit)) != '0) begin
            out_rows_d = out_rows_q + CW'(1);
            out_cols_d = line_cols_q + CW'(emit);
          end
        end else begin
          col_d = c_eff + CW'(1);
          row_d = r_eff;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      lw_q        <= '0;
      pend_q      <= 1'b0;
      ovf_q       <= 1'b0;
      yh_q        <= '0;
      line_cols_q <= '0;
      out_cols_q  <= '0;
      out_rows_q  <= '0;
      fmt_rows_q  <= '0;
      fmt_cols_q  <= '0;
      fcnt_q      <= '0;
      vld_q       <= 1'b0;
      usr_q       <= 1'b0;
      lst_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      col_q       <= col_d;
      row_q       <= row_d;
      lw_q        <= lw_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      yh_q        <= yh_d;
      line_cols_q <= line_cols_d;
      out_cols_q  <= out_cols_d;
      out_rows_q  <= out_rows_d;
      fmt_rows_q  <= fmt_rows_d;
      fmt_cols_q  <= fmt_cols_d;
      fcnt_q      <= fcnt_d;
      vld_q       <= vld_d;
      usr_q       <= usr_d;
      lst_q       <= lst_d;
      dat_q       <= dat_d;
    end
  end

  always_comb begin
    bus.ibus_rddata = '0;
    if (bus.ibus_cs) begin
      case (bus.ibus_addr[7:2])
        REG_CTRL: bus.ibus_rddata = {31'd0, ctrl_q};
        REG_STAT: bus.ibus_rddata = {31'd0, ovf_q};
        REG_FMT:  bus.ibus_rddata = {16'(fmt_rows_q), 16'(fmt_cols_q)};
        REG_FCNT: bus.ibus_rddata = 32'(fcnt_q);
        default:  bus.ibus_rddata = '0;
      endcase
    end
  end

  assign bus.tready_in  = ready_in;
  assign bus.tvalid_out = vld_q;
  assign bus.tuser_out  = usr_q;
  assign bus.tlast_out  = lst_q;
  assign bus.tdata_out  = dat_q;

  assign unused_ok = ^{bus.ibus_addr[1:0], bus.ibus_wrdata[31:1], bus.tdata_in[7:0]};

endmodule
